// File: rtl/sdram_arbit.sv
// ============================================================================
// Module   : sdram_arbit
// Purpose  : Command arbiter for the SDRAM init/refresh/write/read sources.
//            Holds the bus for init and then grants one source at a time.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_arbit #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        init_end,
   input  logic [3:0]  init_cmd,
   input  logic [1:0]  init_bank,
   input  logic [12:0] init_addr,
   input  logic        aref_req,
   input  logic        aref_end,
   input  logic [3:0]  aref_cmd,
   input  logic [1:0]  aref_bank,
   input  logic [12:0] aref_addr,
   input  logic        wr_req,
   input  logic        wr_end,
   input  logic [3:0]  wr_sdram_cmd,
   input  logic [1:0]  wr_sdram_bank,
   input  logic [12:0] wr_sdram_addr,
   input  logic        wr_sdram_en,
   input  logic [15:0] wr_sdram_data,
   input  logic        rd_req,
   input  logic        rd_end,
   input  logic [3:0]  rd_sdram_cmd,
   input  logic [1:0]  rd_sdram_bank,
   input  logic [12:0] rd_sdram_addr,
   output logic        aref_en,
   output logic        wr_en,
   output logic        rd_en,
   output logic        sdram_cke,
   output logic        sdram_cs_n,
   output logic        sdram_ras_n,
   output logic        sdram_cas_n,
   output logic        sdram_we_n,
   output logic [1:0]  sdram_ba,
   output logic [12:0] sdram_addr,
   output logic        sdram_dq_oe,
   output logic [15:0] sdram_dq_out
);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } state_t;

   localparam logic [3:0]  c_CMD_NOP  = 4'b0111;
   localparam logic [1:0]  c_BA_IDLE  = 2'b11;
   localparam logic [12:0] c_ADR_IDLE = 13'h1fff;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_last_wr;
   logic [3:0]  w_cmd;
   logic [1:0]  w_ba;
   logic [12:0] w_addr;
   logic        w_dq_oe;
   logic [15:0] w_dq_out;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state   <= ST_INIT;
         r_last_wr <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_ARBIT && w_next_state == ST_WRITE)
            r_last_wr <= 1'b1;
         else if (r_state == ST_ARBIT && w_next_state == ST_READ)
            r_last_wr <= 1'b0;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_INIT:  if (init_end) w_next_state = ST_ARBIT;
         ST_ARBIT: begin
            if (aref_req)
               w_next_state = ST_AREF;
            // On a write/read tie the read wins only when round-robin is on
            // and the previous grant went to the writer.
            else if (wr_req && rd_req)
               w_next_state = (!RR_EN || !r_last_wr) ? ST_WRITE : ST_READ;
            else if (wr_req)
               w_next_state = ST_WRITE;
            else if (rd_req)
               w_next_state = ST_READ;
         end
         ST_AREF:  if (aref_end) w_next_state = ST_ARBIT;
         ST_WRITE: if (wr_end)   w_next_state = ST_ARBIT;
         ST_READ:  if (rd_end)   w_next_state = ST_ARBIT;
         default:  w_next_state = ST_ARBIT;
      endcase
   end

   always_comb begin
      w_cmd    = c_CMD_NOP;
      w_ba     = c_BA_IDLE;
      w_addr   = c_ADR_IDLE;
      w_dq_oe  = 1'b0;
      w_dq_out = 16'h0000;
      case (r_state)
         ST_INIT: begin
            w_cmd  = init_cmd;
            w_ba   = init_bank;
            w_addr = init_addr;
         end
         ST_AREF: begin
            w_cmd  = aref_cmd;
            w_ba   = aref_bank;
            w_addr = aref_addr;
         end
         ST_WRITE: begin
            w_cmd    = wr_sdram_cmd;
            w_ba     = wr_sdram_bank;
            w_addr   = wr_sdram_addr;
            w_dq_oe  = wr_sdram_en;
            w_dq_out = wr_sdram_data;
         end
         ST_READ: begin
            w_cmd  = rd_sdram_cmd;
            w_ba   = rd_sdram_bank;
            w_addr = rd_sdram_addr;
         end
         default: ;
      endcase
   end

   assign aref_en      = (r_state == ST_AREF);
   assign wr_en        = (r_state == ST_WRITE);
   assign rd_en        = (r_state == ST_READ);
   assign sdram_cke    = 1'b1;
   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
   assign sdram_ba     = w_ba;
   assign sdram_addr   = w_addr;
   assign sdram_dq_oe  = w_dq_oe;
   assign sdram_dq_out = w_dq_out;

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbit.sv
// ============================================================================
// Module   : tb_sdram_arbit
// Purpose  : Self-checking bench for sdram_arbit, round-robin and fixed-priority
//            instances side by side against a behavioural owner model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sdram_arbit;

   localparam int M_INIT = 0, M_IDLE = 1, M_REF = 2, M_WR = 3, M_RD = 4;
   localparam logic [3:0] c_NOP = 4'b0111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0, init_end = 1'b0;
   logic [3:0]  init_cmd = '0, aref_cmd = '0, wr_sdram_cmd = '0, rd_sdram_cmd = '0;
   logic [1:0]  init_bank = '0, aref_bank = '0, wr_sdram_bank = '0, rd_sdram_bank = '0;
   logic [12:0] init_addr = '0, aref_addr = '0, wr_sdram_addr = '0, rd_sdram_addr = '0;
   logic        aref_req = 1'b0, aref_end = 1'b0, wr_req = 1'b0, wr_end = 1'b0;
   logic        rd_req = 1'b0, rd_end = 1'b0, wr_sdram_en = 1'b0;
   logic [15:0] wr_sdram_data = '0;

   logic        ar0, we0, re0, cke0, cs0, ras0, cas0, wen0, oe0;
   logic        ar1, we1, re1, cke1, cs1, ras1, cas1, wen1, oe1;
   logic [1:0]  ba0, ba1;
   logic [12:0] ad0, ad1;
   logic [15:0] dq0, dq1;
   logic [39:0] out0, out1;

   assign out0 = {ar0, we0, re0, cke0, cs0, ras0, cas0, wen0, ba0, ad0, oe0, dq0};
   assign out1 = {ar1, we1, re1, cke1, cs1, ras1, cas1, wen1, ba1, ad1, oe1, dq1};

   sdram_arbit #(.RR_EN(1'b1)) u_rr (
      .sys_clk(clk), .sys_rst_n(rst_n), .init_end(init_end),
      .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
      .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
      .aref_bank(aref_bank), .aref_addr(aref_addr),
      .wr_req(wr_req), .wr_end(wr_end), .wr_sdram_cmd(wr_sdram_cmd),
      .wr_sdram_bank(wr_sdram_bank), .wr_sdram_addr(wr_sdram_addr),
      .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
      .rd_req(rd_req), .rd_end(rd_end), .rd_sdram_cmd(rd_sdram_cmd),
      .rd_sdram_bank(rd_sdram_bank), .rd_sdram_addr(rd_sdram_addr),
      .aref_en(ar0), .wr_en(we0), .rd_en(re0), .sdram_cke(cke0),
      .sdram_cs_n(cs0), .sdram_ras_n(ras0), .sdram_cas_n(cas0), .sdram_we_n(wen0),
      .sdram_ba(ba0), .sdram_addr(ad0), .sdram_dq_oe(oe0), .sdram_dq_out(dq0)
   );

   sdram_arbit #(.RR_EN(1'b0)) u_fix (
      .sys_clk(clk), .sys_rst_n(rst_n), .init_end(init_end),
      .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
      .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
      .aref_bank(aref_bank), .aref_addr(aref_addr),
      .wr_req(wr_req), .wr_end(wr_end), .wr_sdram_cmd(wr_sdram_cmd),
      .wr_sdram_bank(wr_sdram_bank), .wr_sdram_addr(wr_sdram_addr),
      .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
      .rd_req(rd_req), .rd_end(rd_end), .rd_sdram_cmd(rd_sdram_cmd),
      .rd_sdram_bank(rd_sdram_bank), .rd_sdram_addr(rd_sdram_addr),
      .aref_en(ar1), .wr_en(we1), .rd_en(re1), .sdram_cke(cke1),
      .sdram_cs_n(cs1), .sdram_ras_n(ras1), .sdram_cas_n(cas1), .sdram_we_n(wen1),
      .sdram_ba(ba1), .sdram_addr(ad1), .sdram_dq_oe(oe1), .sdram_dq_out(dq1)
   );

   int n_vec = 0, n_err = 0;
   int m_owner [2];
   bit m_last_wr [2];

   typedef struct {
      bit rst_n, ie, aref, aend, wr, wend, rd, rend;
      bit [2:0] exp_grant;
   } vec_t;
   vec_t tbl [20];

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Who owns the bus after this edge, given who owned it before.
   task automatic model_edge(input int i, input bit rr);
      if (!rst_n) begin
         m_owner[i] = M_INIT;
         m_last_wr[i] = 1'b0;
      end else if (m_owner[i] == M_INIT) begin
         if (init_end) m_owner[i] = M_IDLE;
      end else if (m_owner[i] == M_IDLE) begin
         if (aref_req) m_owner[i] = M_REF;
         else if (wr_req && (!rd_req || !rr || !m_last_wr[i])) m_owner[i] = M_WR;
         else if (rd_req) m_owner[i] = M_RD;
         if (m_owner[i] == M_WR) m_last_wr[i] = 1'b1;
         if (m_owner[i] == M_RD) m_last_wr[i] = 1'b0;
      end else if ((m_owner[i] == M_REF && aref_end) || (m_owner[i] == M_WR && wr_end) ||
                   (m_owner[i] == M_RD && rd_end)) begin
         m_owner[i] = M_IDLE;
      end
   endtask

   function automatic logic [39:0] expected(input int owner);
      logic [2:0]  g;
      logic [18:0] bus;
      logic [16:0] dq;
      g = 3'b000;
      bus = {c_NOP, 2'b11, 13'h1fff};
      dq = 17'h0;
      case (owner)
         M_INIT: bus = {init_cmd, init_bank, init_addr};
         M_REF:  begin g = 3'b100; bus = {aref_cmd, aref_bank, aref_addr}; end
         M_WR:   begin
            g = 3'b010; bus = {wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr};
            dq = {wr_sdram_en, wr_sdram_data};
         end
         M_RD:   begin g = 3'b001; bus = {rd_sdram_cmd, rd_sdram_bank, rd_sdram_addr}; end
         default: ;
      endcase
      return {g, 1'b1, bus, dq};
   endfunction

   task automatic rand_data();
      init_cmd = 4'($urandom); init_bank = 2'($urandom); init_addr = 13'($urandom);
      aref_cmd = 4'($urandom); aref_bank = 2'($urandom); aref_addr = 13'($urandom);
      wr_sdram_cmd = 4'($urandom); wr_sdram_bank = 2'($urandom);
      wr_sdram_addr = 13'($urandom); wr_sdram_en = 1'($urandom);
      wr_sdram_data = 16'($urandom);
      rd_sdram_cmd = 4'($urandom); rd_sdram_bank = 2'($urandom); rd_sdram_addr = 13'($urandom);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0, 1'b1);
      model_edge(1, 1'b0);
      #1;
      check("model_rr", out0, expected(m_owner[0]));
      check("model_fix", out1, expected(m_owner[1]));
   endtask

   task automatic set_ctl(input vec_t v);
      rst_n = v.rst_n; init_end = v.ie; aref_req = v.aref; aref_end = v.aend;
      wr_req = v.wr; wr_end = v.wend; rd_req = v.rd; rd_end = v.rend;
   endtask

   initial begin
      byte q0 [$];
      byte q1 [$];
      bit [2:0] p0, p1;
      m_owner[0] = M_INIT; m_owner[1] = M_INIT;
      m_last_wr[0] = 1'b0; m_last_wr[1] = 1'b0;

      //           rst ie ar ae wr we rd re  grant{aref,wr,rd} of RR instance
      tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b000};
      tbl[1]  = '{1, 0, 0, 0, 1, 0, 0, 0, 3'b000};
      tbl[2]  = '{1, 0, 0, 0, 1, 0, 0, 0, 3'b000};
      tbl[3]  = '{1, 1, 0, 0, 1, 0, 0, 0, 3'b000};
      tbl[4]  = '{1, 1, 0, 0, 1, 0, 0, 0, 3'b010};
      tbl[5]  = '{1, 1, 1, 0, 1, 0, 0, 0, 3'b010};
      tbl[6]  = '{1, 1, 1, 0, 0, 1, 0, 0, 3'b000};
      tbl[7]  = '{1, 1, 1, 0, 1, 0, 1, 0, 3'b100};
      tbl[8]  = '{1, 1, 1, 0, 1, 1, 1, 1, 3'b100};
      tbl[9]  = '{1, 1, 0, 1, 1, 0, 1, 0, 3'b000};
      tbl[10] = '{1, 1, 0, 0, 1, 0, 1, 0, 3'b001};
      tbl[11] = '{1, 1, 0, 0, 1, 0, 1, 1, 3'b000};
      tbl[12] = '{1, 1, 0, 0, 1, 0, 1, 0, 3'b010};
      tbl[13] = '{1, 1, 0, 0, 0, 1, 0, 0, 3'b000};
      tbl[14] = '{1, 1, 0, 0, 0, 0, 1, 0, 3'b001};
      tbl[15] = '{0, 1, 0, 0, 0, 0, 0, 1, 3'b000};
      tbl[16] = '{1, 1, 0, 0, 0, 0, 0, 1, 3'b000};
      tbl[17] = '{1, 1, 0, 0, 0, 0, 0, 0, 3'b000};
      tbl[18] = '{1, 1, 0, 0, 0, 0, 1, 0, 3'b001};
      tbl[19] = '{1, 1, 0, 0, 0, 0, 0, 1, 3'b000};

      for (int i = 0; i < 20; i++) begin
         set_ctl(tbl[i]);
         rand_data();
         step();
         check($sformatf("table[%0d] grant", i), 40'({ar0, we0, re0}), 40'(tbl[i].exp_grant));
      end

      // Init hold with a pending write, then release.
      rst_n = 1'b0; wr_req = 1'b1; rd_req = 1'b0; rd_end = 1'b0; init_end = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rand_data();
         step();
         check("init_hold wr_en", 40'(we0), 40'(0));
      end
      init_end = 1'b1;
      step();
      check("init_release nop", 40'({ar0, we0, re0, cs0, ras0, cas0, wen0, ba0, ad0}),
            40'({3'b000, c_NOP, 2'b11, 13'h1fff}));
      wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5C3;
      step();
      check("write dq", 40'({we0, oe0, dq0}), 40'({1'b1, 1'b1, 16'hA5C3}));
      wr_end = 1'b1; wr_req = 1'b0; rd_req = 1'b1;
      step();
      wr_end = 1'b0;
      step();
      check("read dq", 40'({re0, oe0, dq0}), 40'({1'b1, 1'b0, 16'h0000}));

      // Held write+read with periodic end pulses: RR alternates, fixed always writes.
      rst_n = 1'b0; rd_req = 1'b0;
      step();
      rst_n = 1'b1; init_end = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      p0 = 3'b000; p1 = 3'b000;
      for (int c = 0; c < 60; c++) begin
         wr_end = (c % 10 == 9);
         rd_end = (c % 10 == 9);
         step();
         if (p0 == 3'b000 && {ar0, we0, re0} != 3'b000) q0.push_back(we0 ? "W" : "R");
         if (p1 == 3'b000 && {ar1, we1, re1} != 3'b000) q1.push_back(we1 ? "W" : "R");
         p0 = {ar0, we0, re0};
         p1 = {ar1, we1, re1};
      end
      begin
         string exp_rr;
         exp_rr = "WRWR";
         for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_order[%0d]", k), 40'(q0.size() > k ? q0[k] : 8'h00),
                  40'(exp_rr[k]));
            check($sformatf("fix_order[%0d]", k), 40'(q1.size() > k ? q1[k] : 8'h00),
                  40'("W"));
         end
      end

      // Random traffic against the model.
      wr_end = 1'b0; rd_end = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rst_n    = ($urandom_range(0, 99) != 0);
         init_end = ($urandom_range(0, 7) != 0);
         aref_req = ($urandom_range(0, 4) == 0);
         aref_end = ($urandom_range(0, 4) == 0);
         wr_req   = 1'($urandom);
         wr_end   = ($urandom_range(0, 4) == 0);
         rd_req   = 1'($urandom);
         rd_end   = ($urandom_range(0, 4) == 0);
         rand_data();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sdram_arbit.md
# sdram_arbit

Command arbiter between the SDRAM controller's four command sources: init, auto-refresh, write and read. It holds the SDRAM bus for the init sequence until `init_end`. After that it grants the bus to one requester at a time: refresh first, then write or read, with round-robin on a write/read tie. It drives the single SDRAM command/address/data port by muxing the granted module's outputs.

## Interface
- `RR_EN`, 1, 1 = round-robin between simultaneous write/read requests; 0 = write always wins.
- `sys_clk  in  1  system clock, all logic on rising edge`
- `sys_rst_n  in  1  reset, synchronous, active-low`
- `init_end  in  1  init sequence done (level, stays high)`
- `init_cmd  in  4  init command {CS#,RAS#,CAS#,WE#}`
- `init_bank  in  2  init bank address`
- `init_addr  in  13  init address`
- `aref_req  in  1  refresh request (level until served)`
- `aref_end  in  1  refresh done, 1-cycle pulse`
- `aref_cmd  in  4  refresh command`
- `aref_bank  in  2  refresh bank address`
- `aref_addr  in  13  refresh address`
- `wr_req  in  1  write request (level)`
- `wr_end  in  1  write done, 1-cycle pulse`
- `wr_sdram_cmd  in  4  write command`
- `wr_sdram_bank  in  2  write bank address`
- `wr_sdram_addr  in  13  write address`
- `wr_sdram_en  in  1  write data valid / drive dq`
- `wr_sdram_data  in  16  write data`
- `rd_req  in  1  read request (level)`
- `rd_end  in  1  read done, 1-cycle pulse`
- `rd_sdram_cmd  in  4  read command`
- `rd_sdram_bank  in  2  read bank address`
- `rd_sdram_addr  in  13  read address`
- `aref_en  out  1  refresh grant`
- `wr_en  out  1  write grant`
- `rd_en  out  1  read grant`
- `sdram_cke  out  1  clock enable, constant 1`
- `sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins`
- `sdram_ba  out  2  bank`
- `sdram_addr  out  13  address`
- `sdram_dq_oe  out  1  dq output enable`
- `sdram_dq_out  out  16  dq output data`

## Operation
- States: INIT, ARBIT, AREF, WRITE, READ. The state register resets to INIT. Register `last_wr` (last grant was write) resets to 0.
- INIT → ARBIT when `init_end`=1.
- ARBIT:
  - if `aref_req` → AREF;
  - else if `wr_req`&&`rd_req` → WRITE when `RR_EN`=0 or `last_wr`=0, otherwise READ;
  - else if `wr_req` → WRITE;
  - else if `rd_req` → READ;
  - else stay in ARBIT.
- AREF → ARBIT on `aref_end`.
- WRITE → ARBIT on `wr_end`. Set `last_wr`=1 when entering WRITE.
- READ → ARBIT on `rd_end`. Set `last_wr`=0 when entering READ.
- Requests are sampled only in ARBIT. Requests arriving during a grant wait; a running operation is never pre-empted, including by refresh.
- `*_end` inputs are ignored outside their own grant state.
- Grants are combinational from the state register: `aref_en`=(state==AREF), `wr_en`=(state==WRITE), `rd_en`=(state==READ).
- Bus mux, combinational on state; {cs_n,ras_n,cas_n,we_n,ba,addr} are taken from:
  - INIT: `init_*`
  - AREF: `aref_*`
  - WRITE: `wr_sdram_*`
  - READ: `rd_sdram_*`
  - ARBIT: NOP 4'b0111, ba 2'b11, addr 13'h1fff
- `sdram_dq_oe` = `wr_sdram_en` in WRITE, else 0. `sdram_dq_out` = `wr_sdram_data` in WRITE, else 16'h0000.
- Undefined state encodings recover to ARBIT and drive NOP.

## Timing
- Reset: during and after a reset edge, state=INIT and `aref_en`/`wr_en`/`rd_en`/`sdram_dq_oe`=0. `sdram_dq_out`=0, `sdram_cke`=1, and command/bank/address follow `init_*`.
- Grant latency: a request seen in ARBIT at edge N gives a grant visible in cycle N+1.
- Release: an end pulse at edge N puts the block in ARBIT for cycle N+1, with grant low and NOP driven. There is at least one ARBIT cycle between any two grants.
- Back-to-back: a request still held gets its grant two cycles after the end pulse.
- Mux delay: zero cycles; the selected module's outputs appear in the same cycle.
- Reset mid-grant: the block returns to INIT on the next edge, and grants and dq_oe drop in that cycle.
- Simultaneous end pulse and new request: the end pulse is honoured, and the request is arbitrated in the following ARBIT cycle.

## Test plan
- Init hold → release: `init_end`=0 with `wr_req`=1 for 20 cycles → `wr_en`=0, bus = `init_*`. Raise `init_end` → ARBIT one cycle (NOP, ba 3, addr 1fff), then `wr_en`=1.
- Refresh priority: in ARBIT, `aref_req`=`wr_req`=`rd_req`=1 → `aref_en`=1 only. After `aref_end` → one ARBIT cycle, then `wr_en`=1.
- Round-robin (`RR_EN`=1): `wr_req`=`rd_req` held, `end` pulses every 10 cycles → grants alternate W,R,W,R. With `RR_EN`=0 → grants W,W,W.
- No pre-emption: assert `aref_req` mid-WRITE → `wr_en` stays 1 until `wr_end`, then `aref_en`=1 two cycles after the `wr_end` edge.
- Data path: in WRITE with `wr_sdram_en`=1 and `wr_sdram_data`=16'hA5C3 → `sdram_dq_oe`=1 and `dq_out`=A5C3 in the same cycle. In READ → `dq_oe`=0 and `dq_out`=0.
- Reset mid-READ: drive `sys_rst_n`=0 for one edge → `rd_en`=0 next cycle, state INIT, stray `rd_end` ignored.
